// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART0 ICB init sequencer: FSM states,
// 16550 register offsets, init constants and the per-step offset table.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HST_RSP = 2'd1,
    SEQ_CMD = 2'd2,
    SEQ_RSP = 2'd3
  } state_e;

  localparam logic [2:0] OFS_THR_DLL = 3'd0;
  localparam logic [2:0] OFS_IER_DLM = 3'd1;
  localparam logic [2:0] OFS_FCR     = 3'd2;
  localparam logic [2:0] OFS_LCR     = 3'd3;

  localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
  localparam logic [7:0] LCR_8N1      = 8'h03;
  localparam logic [7:0] FCR_INIT     = 8'h07;

  localparam logic [2:0] SEQ_LAST = 3'd5;

  // Offset of each init step: unlock divisor latch, DLL, DLM, relock, FIFO, IER
  function automatic logic [2:0] step_offset(input logic [2:0] step);
    case (step)
      3'd0:    step_offset = OFS_LCR;
      3'd1:    step_offset = OFS_THR_DLL;
      3'd2:    step_offset = OFS_IER_DLM;
      3'd3:    step_offset = OFS_LCR;
      3'd4:    step_offset = OFS_FCR;
      default: step_offset = OFS_IER_DLM;
    endcase
  endfunction

endpackage

// File: rtl/uart_icb_ctrl.sv
// ICB front-end for UART0: passes host traffic through when idle and, on
// cfg_start, owns the master port to issue the six-write UART init sequence.
module uart_icb_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = 32'h1001_3000,
  parameter logic [15:0]     DIVISOR   = 16'd27,
  parameter logic [7:0]      IER_VAL   = 8'h01
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_start,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_err,
  input  logic          hst_icb_cmd_valid,
  output logic          hst_icb_cmd_ready,
  input  logic [AW-1:0] hst_icb_cmd_addr,
  input  logic          hst_icb_cmd_read,
  input  logic [DW-1:0] hst_icb_cmd_wdata,
  input  logic [3:0]    hst_icb_cmd_wmask,
  output logic          hst_icb_rsp_valid,
  input  logic          hst_icb_rsp_ready,
  output logic [DW-1:0] hst_icb_rsp_rdata,
  output logic          hst_icb_rsp_err,
  output logic          m_icb_cmd_valid,
  input  logic          m_icb_cmd_ready,
  output logic [AW-1:0] m_icb_cmd_addr,
  output logic          m_icb_cmd_read,
  output logic [DW-1:0] m_icb_cmd_wdata,
  output logic [3:0]    m_icb_cmd_wmask,
  input  logic          m_icb_rsp_valid,
  output logic          m_icb_rsp_ready,
  input  logic [DW-1:0] m_icb_rsp_rdata,
  input  logic          m_icb_rsp_err
);

  state_e      r_state;
  logic [2:0]  r_step;
  logic        r_cfg_done;
  logic        r_cfg_err;

  logic          w_hst_pass;
  logic          w_seq_cmd;
  logic          w_hst_rsp;
  logic [7:0]    w_seq_byte;
  logic [AW-1:0] w_seq_addr;

  always_comb begin
    w_seq_byte = IER_VAL;
    case (r_step)
      3'd0:    w_seq_byte = LCR_DLAB_8N1;
      3'd1:    w_seq_byte = DIVISOR[7:0];
      3'd2:    w_seq_byte = DIVISOR[15:8];
      3'd3:    w_seq_byte = LCR_8N1;
      3'd4:    w_seq_byte = FCR_INIT;
      default: w_seq_byte = IER_VAL;
    endcase
  end

  assign w_seq_addr = BASE_ADDR + AW'(step_offset(r_step));

  // cfg_start steals the idle cycle from any host command presented with it
  assign w_hst_pass = (r_state == IDLE) && !cfg_start;
  assign w_seq_cmd  = (r_state == SEQ_CMD);
  assign w_hst_rsp  = (r_state == HST_RSP);

  assign m_icb_cmd_valid   = w_hst_pass ? hst_icb_cmd_valid : w_seq_cmd;
  assign m_icb_cmd_addr    = w_seq_cmd ? w_seq_addr : hst_icb_cmd_addr;
  assign m_icb_cmd_read    = w_seq_cmd ? 1'b0 : hst_icb_cmd_read;
  assign m_icb_cmd_wdata   = w_seq_cmd ? {{(DW-8){1'b0}}, w_seq_byte} : hst_icb_cmd_wdata;
  assign m_icb_cmd_wmask   = w_seq_cmd ? 4'hF : hst_icb_cmd_wmask;
  assign hst_icb_cmd_ready = w_hst_pass && m_icb_cmd_ready;

  assign m_icb_rsp_ready   = w_hst_rsp ? hst_icb_rsp_ready : (r_state == SEQ_RSP);
  assign hst_icb_rsp_valid = w_hst_rsp && m_icb_rsp_valid;
  assign hst_icb_rsp_rdata = m_icb_rsp_rdata;
  assign hst_icb_rsp_err   = m_icb_rsp_err;

  assign cfg_busy = w_seq_cmd || (r_state == SEQ_RSP);
  assign cfg_done = r_cfg_done;
  assign cfg_err  = r_cfg_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_step     <= 3'd0;
      r_cfg_done <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_state   <= SEQ_CMD;
            r_step    <= 3'd0;
            r_cfg_err <= 1'b0;
          end else if (hst_icb_cmd_valid && m_icb_cmd_ready) begin
            r_state <= HST_RSP;
          end
        end
        HST_RSP: begin
          if (m_icb_rsp_valid && hst_icb_rsp_ready) r_state <= IDLE;
        end
        SEQ_CMD: begin
          if (m_icb_cmd_ready) r_state <= SEQ_RSP;
        end
        default: begin
          // Error responses are recorded but never cut the sequence short
          if (m_icb_rsp_valid) begin
            r_cfg_err <= r_cfg_err | m_icb_rsp_err;
            if (r_step == SEQ_LAST) begin
              r_cfg_done <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_step  <= r_step + 3'd1;
              r_state <= SEQ_CMD;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_icb_ctrl.sv
// Bench for uart_icb_ctrl: behavioural UART register slave behind the master
// port, command/response scoreboards fed as stimulus is issued.
module tb_uart_icb_ctrl;

  localparam logic [31:0] BASE = 32'h1001_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_busy, cfg_done, cfg_err;
  logic        hst_icb_cmd_valid = 1'b0;
  logic        hst_icb_cmd_ready;
  logic [31:0] hst_icb_cmd_addr = '0;
  logic        hst_icb_cmd_read = 1'b0;
  logic [31:0] hst_icb_cmd_wdata = '0;
  logic [3:0]  hst_icb_cmd_wmask = 4'h0;
  logic        hst_icb_rsp_valid;
  logic        hst_icb_rsp_ready = 1'b1;
  logic [31:0] hst_icb_rsp_rdata;
  logic        hst_icb_rsp_err;
  logic        m_icb_cmd_valid;
  logic        m_icb_cmd_ready = 1'b1;
  logic [31:0] m_icb_cmd_addr;
  logic        m_icb_cmd_read;
  logic [31:0] m_icb_cmd_wdata;
  logic [3:0]  m_icb_cmd_wmask;
  logic        m_icb_rsp_valid = 1'b0;
  logic        m_icb_rsp_ready;
  logic [31:0] m_icb_rsp_rdata = '0;
  logic        m_icb_rsp_err = 1'b0;

  always #5 clk = ~clk;

  uart_icb_ctrl dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .hst_icb_cmd_valid(hst_icb_cmd_valid), .hst_icb_cmd_ready(hst_icb_cmd_ready),
    .hst_icb_cmd_addr(hst_icb_cmd_addr), .hst_icb_cmd_read(hst_icb_cmd_read),
    .hst_icb_cmd_wdata(hst_icb_cmd_wdata), .hst_icb_cmd_wmask(hst_icb_cmd_wmask),
    .hst_icb_rsp_valid(hst_icb_rsp_valid), .hst_icb_rsp_ready(hst_icb_rsp_ready),
    .hst_icb_rsp_rdata(hst_icb_rsp_rdata), .hst_icb_rsp_err(hst_icb_rsp_err),
    .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
    .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
    .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
    .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
    .m_icb_rsp_rdata(m_icb_rsp_rdata), .m_icb_rsp_err(m_icb_rsp_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd;
    logic [3:0]  mask;
  } cmd_t;

  cmd_t        exp_q[$];
  logic [31:0] rsp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  int          err_at = -1;
  bit          rnd_ready = 1'b0;
  bit          busy_seen = 1'b0;

  int unsigned seq_ofs[6] = '{3, 0, 1, 3, 2, 1};
  logic [7:0]  seq_dat[6] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h01};

  logic [7:0] sv_reg[8];
  logic [7:0] sv_dll, sv_dlm;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural UART register slave, one-cycle response latency
  initial for (int i = 0; i < 8; i++) sv_reg[i] = 8'h00;

  always @(posedge clk) begin
    m_icb_cmd_ready <= rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst) begin
      m_icb_rsp_valid <= 1'b0;
    end else begin
      if (m_icb_rsp_valid && m_icb_rsp_ready) m_icb_rsp_valid <= 1'b0;
      if (m_icb_cmd_valid && m_icb_cmd_ready) begin
        m_icb_rsp_valid <= 1'b1;
        m_icb_rsp_err   <= 1'b0;
        m_icb_rsp_rdata <= '0;
        if (m_icb_cmd_read) begin
          if (m_icb_cmd_addr[2:0] == 3'd5) m_icb_rsp_rdata <= 32'h60;
          else m_icb_rsp_rdata <= {24'h0, sv_reg[m_icb_cmd_addr[2:0]]};
        end else begin
          m_icb_rsp_err <= (wr_cnt == err_at);
          wr_cnt <= wr_cnt + 1;
          if (sv_reg[3][7] && m_icb_cmd_addr[2:0] == 3'd0) sv_dll <= m_icb_cmd_wdata[7:0];
          else if (sv_reg[3][7] && m_icb_cmd_addr[2:0] == 3'd1) sv_dlm <= m_icb_cmd_wdata[7:0];
          else sv_reg[m_icb_cmd_addr[2:0]] <= m_icb_cmd_wdata[7:0];
        end
      end
    end
  end

  logic        prev_stall = 1'b0;
  logic        prev_done = 1'b0;
  logic [31:0] prev_addr, prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (cfg_busy) busy_seen = 1'b1;
      if (cfg_done) done_cnt++;
      if (cfg_done && prev_done) chk("done_width", 1, 0);
      prev_done = cfg_done;
      if (prev_stall && cfg_busy) begin
        chk("hold_valid", m_icb_cmd_valid, 1);
        chk("hold_addr", m_icb_cmd_addr, prev_addr);
        chk("hold_data", m_icb_cmd_wdata, prev_data);
      end
      prev_stall = m_icb_cmd_valid && !m_icb_cmd_ready;
      prev_addr  = m_icb_cmd_addr;
      prev_data  = m_icb_cmd_wdata;
      if (m_icb_cmd_valid && m_icb_cmd_ready) begin
        if (exp_q.size() == 0) chk("cmd_unexpected", m_icb_cmd_addr, 0);
        else begin
          cmd_t e;
          e = exp_q.pop_front();
          chk("cmd_addr", m_icb_cmd_addr, e.addr);
          chk("cmd_wdata", m_icb_cmd_wdata, e.data);
          chk("cmd_read", m_icb_cmd_read, e.rd);
          chk("cmd_wmask", m_icb_cmd_wmask, e.mask);
        end
      end
      if (hst_icb_rsp_valid && hst_icb_rsp_ready) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", hst_icb_rsp_rdata, 0);
        else chk("hst_rdata", hst_icb_rsp_rdata, rsp_q.pop_front());
      end
    end
  end

  task automatic push_seq();
    for (int i = 0; i < 6; i++) begin
      cmd_t c;
      c.addr = BASE + seq_ofs[i];
      c.data = {24'h0, seq_dat[i]};
      c.rd   = 1'b0;
      c.mask = 4'hF;
      exp_q.push_back(c);
    end
  endtask

  task automatic start_seq();
    push_seq();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("busy_after_start", cfg_busy, 1);
    chk("err_cleared_on_start", cfg_err, 0);
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (cfg_done) begin got = 1'b1; break; end
    end
    if (!got) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_wr(input int target, input int budget);
    bit got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (wr_cnt >= target) begin got = 1'b1; break; end
    end
    if (!got) chk("wr_timeout", wr_cnt, target);
  endtask

  // Host transfer; cmd pushed to the scoreboard only when caller asks
  task automatic host_xfer(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input bit push);
    bit got;
    cmd_t c;
    c.addr = addr; c.data = wd; c.rd = rd; c.mask = rd ? 4'h0 : 4'hF;
    if (push) exp_q.push_back(c);
    rsp_q.push_back(exp_rd);
    hst_icb_cmd_addr = addr; hst_icb_cmd_read = rd;
    hst_icb_cmd_wdata = wd;  hst_icb_cmd_wmask = c.mask;
    hst_icb_cmd_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (hst_icb_cmd_ready) begin got = 1'b1; break; end
    end
    if (!got) chk("hst_cmd_timeout", 0, 1);
    @(posedge clk); #1;
    hst_icb_cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (hst_icb_rsp_valid) begin got = 1'b1; break; end
    end
    if (!got) chk("hst_rsp_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0, w0;
    repeat (3) @(negedge clk);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_m_valid", m_icb_cmd_valid, 0);
    chk("rst_m_rsp_ready", m_icb_rsp_ready, 0);
    chk("rst_hst_rsp_valid", hst_icb_rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full init sequence, then LCR readback
    d0 = done_cnt;
    start_seq();
    wait_done(100);
    repeat (3) @(posedge clk); #1;
    chk("seq1_done_cnt", done_cnt - d0, 1);
    chk("seq1_q_empty", exp_q.size(), 0);
    chk("seq1_err", cfg_err, 0);
    chk("seq1_divisor", {sv_dlm, sv_dll}, 16'd27);
    host_xfer(BASE + 3, 1'b1, 32'h0, 32'h03, 1'b1);

    // LSR read passes straight through while idle
    busy_seen = 1'b0;
    host_xfer(BASE + 5, 1'b1, 32'h0, 32'h60, 1'b1);
    chk("lsr_busy_seen", busy_seen, 0);

    // cfg_start and host command in the same cycle: host waits for the sequence
    d0 = done_cnt;
    push_seq();
    cfg_start = 1'b1;
    hst_icb_cmd_valid = 1'b1;
    hst_icb_cmd_addr = BASE + 7; hst_icb_cmd_read = 1'b0;
    hst_icb_cmd_wdata = 32'hA5;  hst_icb_cmd_wmask = 4'hF;
    #1;
    chk("coll_hst_ready", hst_icb_cmd_ready, 0);
    chk("coll_m_valid", m_icb_cmd_valid, 0);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("coll_busy", cfg_busy, 1);
    host_xfer(BASE + 7, 1'b0, 32'hA5, 32'h0, 1'b1);
    chk("coll_done_cnt", done_cnt - d0, 1);
    chk("coll_q_empty", exp_q.size(), 0);
    host_xfer(BASE + 7, 1'b1, 32'h0, 32'hA5, 1'b1);

    // Error on step 2 is sticky but does not abort
    w0 = wr_cnt;
    err_at = wr_cnt + 2;
    start_seq();
    wait_done(100);
    err_at = -1;
    chk("err_writes", wr_cnt - w0, 6);
    chk("err_sticky", cfg_err, 1);
    start_seq();
    wait_done(100);
    chk("err_cleared_end", cfg_err, 0);

    // Reset during step 3 response phase
    d0 = done_cnt;
    w0 = wr_cnt;
    start_seq();
    wait_wr(w0 + 4, 50);
    chk("mid_in_rsp", m_icb_rsp_ready, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", cfg_busy, 0);
    chk("mid_rst_done", cfg_done, 0);
    chk("mid_rst_m_valid", m_icb_cmd_valid, 0);
    chk("mid_rst_m_rsp_ready", m_icb_rsp_ready, 0);
    chk("mid_rst_hst_rsp", hst_icb_rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge clk); #1;
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_idle_busy", cfg_busy, 0);
    start_seq();
    wait_done(100);
    chk("mid_restart_q", exp_q.size(), 0);

    // cfg_start while busy is ignored; random ready exercises hold
    rnd_ready = 1'b1;
    d0 = done_cnt;
    w0 = wr_cnt;
    start_seq();
    wait_wr(w0 + 2, 100);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    wait_done(200);
    repeat (20) @(posedge clk); #1;
    rnd_ready = 1'b0;
    chk("ign_writes", wr_cnt - w0, 6);
    chk("ign_done_cnt", done_cnt - d0, 1);
    chk("ign_q_empty", exp_q.size(), 0);
    chk("ign_rsp_q_empty", rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_icb_ctrl.md
UART_ICB_CTRL -- requirements
Module: uart_icb_ctrl

Interface
REQ-001 Parameter: AW, 32, ICB address width.
REQ-002 Parameter: DW, 32, ICB data width.
REQ-003 Parameter: BASE_ADDR, 32'h1001_3000, UART0 register base.
REQ-004 Parameter: DIVISOR, 16'd27, baud divisor written to DLL/DLM.
REQ-005 Parameter: IER_VAL, 8'h01, final IER value (RX data interrupt).
REQ-006 Port: clk  in  1  sole clock; all state on rising edge.
REQ-007 Port: rst  in  1  asynchronous, active-high reset.
REQ-008 Port: cfg_start  in  1  single-cycle request to run the init sequence.
REQ-009 Port: cfg_busy  out  1  sequencer owns the master port.
REQ-010 Port: cfg_done  out  1  one-cycle pulse after the last sequence response.
REQ-011 Port: cfg_err  out  1  sticky; any sequence response had err=1.
REQ-012 Ports: hst_icb_cmd_{valid in 1, ready out 1, addr in AW, read in 1, wdata in DW, wmask in 4}  host command channel.
REQ-013 Ports: hst_icb_rsp_{valid out 1, ready in 1, rdata out DW, err out 1}  host response channel.
REQ-014 Ports: m_icb_cmd_{valid out 1, ready in 1, addr out AW, read out 1, wdata out DW, wmask out 4}  to sirv_gnrl_icb2apb.
REQ-015 Ports: m_icb_rsp_{valid in 1, ready out 1, rdata in DW, err in 1}  from sirv_gnrl_icb2apb.

Function
REQ-016 FSM states SHALL be IDLE, HST_RSP, SEQ_CMD, SEQ_RSP; one outstanding transaction at most.
REQ-017 IDLE, cfg_start=1: SHALL go to SEQ_CMD, clear step counter to 0 and clear cfg_err; cfg_start wins over a simultaneous host command (hst_icb_cmd_ready=0 that cycle).
REQ-018 IDLE, no cfg_start: host cmd SHALL pass combinationally to m_icb_cmd_*; hst_icb_cmd_ready = m_icb_cmd_ready; on handshake go to HST_RSP.
REQ-019 HST_RSP: m_icb_rsp_* SHALL route to hst_icb_rsp_*, m_icb_rsp_ready = hst_icb_rsp_ready; on handshake return to IDLE; hst_icb_cmd_ready=0.
REQ-020 SEQ_CMD: m_icb_cmd_valid=1, read=0, wmask=4'hF, wdata={24'h0,byte}, addr=BASE_ADDR+offset per step; on handshake go to SEQ_RSP.
REQ-021 Step table (offset, byte): 0:(3,8'h83) 1:(0,DIVISOR[7:0]) 2:(1,DIVISOR[15:8]) 3:(3,8'h03) 4:(2,8'h07) 5:(1,IER_VAL).
REQ-022 SEQ_RSP: m_icb_rsp_ready=1; on rsp valid, cfg_err |= err; step<5 -> step+1, SEQ_CMD; step=5 -> cfg_done=1 for one cycle, IDLE.
REQ-023 An error response SHALL NOT abort the sequence.
REQ-024 cfg_start outside IDLE SHALL be ignored (not queued).
REQ-025 cfg_busy = (state is SEQ_CMD or SEQ_RSP); hst_icb_cmd_ready=0 and hst_icb_rsp_valid=0 while busy.
REQ-026 m_icb_cmd_valid SHALL stay asserted with stable addr/wdata until ready (ICB hold rule).

Reset
REQ-027 On rst: state IDLE, step 0, cfg_busy=0, cfg_done=0, cfg_err=0, m_icb_cmd_valid=0 (no host valid), m_icb_rsp_ready=0, hst_icb_rsp_valid=0.
REQ-028 rst mid-transaction SHALL abandon it; no cfg_done is produced; a new sequence needs a new cfg_start.

Structure
REQ-029 Step offsets, LCR/FCR constants and the FSM state enum SHALL live in a shared package uart_ctrl_pkg.
REQ-030 Single flat module; no sub-module. Bench instantiates it ahead of sirv_gnrl_icb2apb + apb_uart.

Verification
REQ-031 cfg_start after reset, zero-wait bridge -> six writes in order 0x10013003/83, 0x10013000/1B, 0x10013001/00, 0x10013003/03, 0x10013002/07, 0x10013001/01; cfg_done pulses once; UART LCR reads 0x03.
REQ-032 Host read 0x10013005 in IDLE -> passed through; hst rsp rdata bit6..5 = 2'b11 (LSR THRE/TEMT); cfg_busy stays 0.
REQ-033 cfg_start and host cmd valid same cycle -> host stalled until cfg_done, then its command completes.
REQ-034 Forced m_icb_rsp_err=1 on step 2 -> all six writes still issued; cfg_err=1 after cfg_done; next cfg_start clears it.
REQ-035 rst asserted during step 3 SEQ_RSP -> all outputs at reset values same cycle; no cfg_done; later cfg_start runs full sequence from step 0.
REQ-036 cfg_start pulsed while busy -> ignored; exactly six writes, one cfg_done.
